// File: rtl/vga_sync_decoder_if.sv
// Interface for the VGA sync decoder: the horizontal counter drives
// cntHorizontal/vflag in, and the decoded timing comes back out.
interface vga_sync_decoder_if;
  logic [10:0] cntHorizontal;
  logic        vflag;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        pixel_tick;
  logic        frame_start;

  // Producer side: horizontal counter plus whoever consumes the timing.
  modport master (
    output cntHorizontal, vflag,
    input  hsync, vsync, video_on, pixel_x, pixel_y, pixel_tick, frame_start
  );

  // Decoder side.
  modport slave (
    input  cntHorizontal, vflag,
    output hsync, vsync, video_on, pixel_x, pixel_y, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync_decoder.sv
// VGA 640x480@60 sync decoder: keeps the vertical line counter from the
// end-of-line flag and decodes registered sync, blanking and coordinates
// from the free-running horizontal clock count.
module vga_sync_decoder #(
  parameter int unsigned H_VISIBLE   = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_VISIBLE   = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned CLK_PER_PIX = 2,
  parameter logic        SYNC_POL    = 1'b0
) (
  input logic                Clk,
  input logic                Reset,
  vga_sync_decoder_if.slave  bus
);

  // Horizontal window edges in clock units (end values are exclusive).
  localparam logic [10:0] HC_VIS_END    = 11'(H_VISIBLE * CLK_PER_PIX);
  localparam logic [10:0] HC_SYNC_START = 11'((H_VISIBLE + H_FP) * CLK_PER_PIX);
  localparam logic [10:0] HC_SYNC_END   = 11'((H_VISIBLE + H_FP + H_SYNC) * CLK_PER_PIX);
  localparam logic [10:0] HC_TOTAL      = 11'((H_VISIBLE + H_FP + H_SYNC + H_BP) * CLK_PER_PIX);
  localparam logic [10:0] CPP           = 11'(CLK_PER_PIX);

  // Last line number of each vertical region.
  localparam logic [9:0]  V_ACT_LAST    = 10'(V_VISIBLE - 1);
  localparam logic [9:0]  V_FP_LAST     = 10'(V_VISIBLE + V_FP - 1);
  localparam logic [9:0]  V_SYNC_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam logic [9:0]  V_LAST        = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0]  V_VIS_END     = 10'(V_VISIBLE);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_FRONT  = 2'd1,
    ST_SYNC   = 2'd2,
    ST_BACK   = 2'd3
  } vstate_e;

  vstate_e     vstate_q, vstate_d;
  logic [9:0]  vcount_q, vcount_d;
  logic [9:0]  vcount_inc;
  logic [9:0]  vline;
  logic [10:0] hc;
  logic        hc_in_range;
  logic        hc_visible;
  logic        hc_in_sync;

  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        video_on_q, video_on_d;
  logic [9:0]  pixel_x_q, pixel_x_d;
  logic [9:0]  pixel_y_q, pixel_y_d;
  logic        pixel_tick_q, pixel_tick_d;
  logic        frame_start_q, frame_start_d;

  assign hc = bus.cntHorizontal;

  // Vertical counter and region tracking; both move only on the end-of-line flag.
  always_comb begin
    vcount_inc = (vcount_q == V_LAST) ? 10'd0 : vcount_q + 10'd1;
    vcount_d   = vcount_q;
    vline      = vcount_q;
    vstate_d   = vstate_q;
    if (bus.vflag) begin
      vcount_d = vcount_inc;
      vline    = vcount_inc;
      case (vstate_q)
        ST_ACTIVE: begin
          if (vcount_q == V_ACT_LAST) vstate_d = ST_FRONT;
          else                        vstate_d = ST_ACTIVE;
        end
        ST_FRONT: begin
          if (vcount_q == V_FP_LAST)  vstate_d = ST_SYNC;
          else                        vstate_d = ST_FRONT;
        end
        ST_SYNC: begin
          if (vcount_q == V_SYNC_LAST) vstate_d = ST_BACK;
          else                         vstate_d = ST_SYNC;
        end
        ST_BACK: begin
          if (vcount_q == V_LAST)     vstate_d = ST_ACTIVE;
          else                        vstate_d = ST_BACK;
        end
        default: vstate_d = ST_ACTIVE;
      endcase
    end else begin
      vstate_d = vstate_q;
    end
  end

  // Output decode from the current horizontal count and the effective line.
  always_comb begin
    hc_in_range   = (hc < HC_TOTAL);
    hc_visible    = hc_in_range && (hc < HC_VIS_END);
    hc_in_sync    = hc_in_range && (hc >= HC_SYNC_START) && (hc < HC_SYNC_END);
    video_on_d    = hc_visible && (vline < V_VIS_END);
    hsync_d       = hc_in_sync ? SYNC_POL : ~SYNC_POL;
    vsync_d       = (vstate_d == ST_SYNC) ? SYNC_POL : ~SYNC_POL;
    frame_start_d = bus.vflag && (vcount_q == V_LAST);
    if (video_on_d) begin
      pixel_x_d    = 10'(hc / CPP);
      pixel_y_d    = vline;
      pixel_tick_d = ((hc % CPP) == 11'd0);
    end else begin
      pixel_x_d    = 10'd0;
      pixel_y_d    = 10'd0;
      pixel_tick_d = 1'b0;
    end
  end

  // State and output registers; reset wins over a coincident end-of-line flag.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      vstate_q      <= ST_ACTIVE;
      vcount_q      <= 10'd0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      pixel_x_q     <= 10'd0;
      pixel_y_q     <= 10'd0;
      pixel_tick_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      vstate_q      <= vstate_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      pixel_x_q     <= pixel_x_d;
      pixel_y_q     <= pixel_y_d;
      pixel_tick_q  <= pixel_tick_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.video_on    = video_on_q;
  assign bus.pixel_x     = pixel_x_q;
  assign bus.pixel_y     = pixel_y_q;
  assign bus.pixel_tick  = pixel_tick_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Self-checking bench for vga_sync_decoder: a line-number model predicts
// every output each cycle, plus literal spot checks at the timing edges.
module tb_vga_sync_decoder;

  logic Clk;
  logic Reset;
  vga_sync_decoder_if bus();

  vga_sync_decoder dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks   = 0;
  int failures = 0;

  // Model state: current line number 0..524
  int m_line = 0;
  int e_hs, e_vs, e_von, e_px, e_py, e_tick, e_fs;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model + compare: predict outputs from the inputs seen at this edge,
  // then check the DUT's registered outputs shortly afterwards.
  always @(posedge Clk) begin
    int hc;
    int le;
    bit vis;
    hc = int'(bus.cntHorizontal);
    if (Reset) begin
      m_line = 0;
      e_hs = 1; e_vs = 1; e_von = 0; e_px = 0; e_py = 0; e_tick = 0; e_fs = 0;
    end else begin
      e_fs = 0;
      if (bus.vflag) begin
        e_fs   = (m_line == 524) ? 1 : 0;
        m_line = (m_line + 1) % 525;
      end
      le     = m_line;
      vis    = (hc < 1280) && (le < 480);
      e_hs   = (hc >= 1312 && hc <= 1503) ? 0 : 1;
      e_vs   = (le == 490 || le == 491) ? 0 : 1;
      e_von  = vis ? 1 : 0;
      e_px   = vis ? hc / 2 : 0;
      e_py   = vis ? le : 0;
      e_tick = (vis && (hc % 2 == 0)) ? 1 : 0;
    end
    #2;
    chk("hsync",       32'(bus.hsync),       32'(e_hs));
    chk("vsync",       32'(bus.vsync),       32'(e_vs));
    chk("video_on",    32'(bus.video_on),    32'(e_von));
    chk("pixel_x",     32'(bus.pixel_x),     32'(e_px));
    chk("pixel_y",     32'(bus.pixel_y),     32'(e_py));
    chk("pixel_tick",  32'(bus.pixel_tick),  32'(e_tick));
    chk("frame_start", 32'(bus.frame_start), 32'(e_fs));
  end

  // Drive one cycle of inputs; returns once the resulting outputs are visible.
  task automatic step(input int hc, input bit vf, input bit rst);
    @(negedge Clk);
    bus.cntHorizontal = 11'(hc);
    bus.vflag         = vf;
    Reset             = rst;
    @(posedge Clk);
    #3;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_hsync"},    32'(bus.hsync),       32'd1);
    chk({tag, "_vsync"},    32'(bus.vsync),       32'd1);
    chk({tag, "_video_on"}, 32'(bus.video_on),    32'd0);
    chk({tag, "_pixel_x"},  32'(bus.pixel_x),     32'd0);
    chk({tag, "_pixel_y"},  32'(bus.pixel_y),     32'd0);
    chk({tag, "_fs"},       32'(bus.frame_start), 32'd0);
  endtask

  int hs_low, ticks, vs_low, von_cnt, guard;

  initial begin
    Reset             = 1'b1;
    bus.cntHorizontal = 11'($urandom_range(0, 2047));
    bus.vflag         = 1'($urandom_range(0, 1));

    // Reset held with random inputs
    repeat (3) step(int'($urandom_range(0, 2047)), 1'($urandom_range(0, 1)), 1'b1);
    chk_reset_vals("reset");

    // Sweep one full line on line 0
    hs_low = 0; ticks = 0;
    for (int hc = 0; hc < 1600; hc++) begin
      step(hc, 1'b0, 1'b0);
      if (bus.hsync == 1'b0) hs_low++;
      if (bus.pixel_tick == 1'b1) ticks++;
      if (hc == 0) begin
        chk("sweep0_von", 32'(bus.video_on), 32'd1);
        chk("sweep0_tick", 32'(bus.pixel_tick), 32'd1);
      end
      if (hc == 1279) begin
        chk("sweep1279_px", 32'(bus.pixel_x), 32'd639);
        chk("sweep1279_tick", 32'(bus.pixel_tick), 32'd0);
      end
      if (hc == 1280) chk("sweep1280_von", 32'(bus.video_on), 32'd0);
      if (hc == 1311) chk("sweep1311_hs", 32'(bus.hsync), 32'd1);
      if (hc == 1312) chk("sweep1312_hs", 32'(bus.hsync), 32'd0);
      if (hc == 1503) chk("sweep1503_hs", 32'(bus.hsync), 32'd0);
      if (hc == 1504) chk("sweep1504_hs", 32'(bus.hsync), 32'd1);
    end
    chk("hsync_low_clocks", 32'(hs_low), 32'd192);
    chk("tick_count", 32'(ticks), 32'd640);

    // Short lines up to 487
    for (int l = 1; l <= 487; l++) begin
      step(0, 1'b1, 1'b0);
      if (l == 479) chk("line479_py", 32'(bus.pixel_y), 32'd479);
      if (l == 480) chk("line480_von", 32'(bus.video_on), 32'd0);
      repeat (3) step(int'($urandom_range(0, 1799)), 1'b0, 1'b0);
    end

    // Full lines through the vertical sync region
    vs_low = 0; von_cnt = 0;
    for (int l = 488; l <= 494; l++) begin
      for (int hc = 0; hc < 1600; hc++) begin
        step(hc, (hc == 0), 1'b0);
        if (bus.vsync == 1'b0) vs_low++;
        if (bus.video_on == 1'b1) von_cnt++;
      end
    end
    chk("vsync_low_clocks", 32'(vs_low), 32'd3200);
    chk("blank_video_on", 32'(von_cnt), 32'd0);

    // Short lines up to 524, then the frame wrap
    for (int l = 495; l <= 524; l++) begin
      step(0, 1'b1, 1'b0);
      chk("pre_wrap_fs", 32'(bus.frame_start), 32'd0);
      repeat (2) step(int'($urandom_range(0, 1599)), 1'b0, 1'b0);
    end
    step(0, 1'b1, 1'b0);
    chk("wrap_fs", 32'(bus.frame_start), 32'd1);
    chk("wrap_py", 32'(bus.pixel_y), 32'd0);
    chk("wrap_von", 32'(bus.video_on), 32'd1);
    step(2, 1'b0, 1'b0);
    chk("wrap_fs_once", 32'(bus.frame_start), 32'd0);
    chk("wrap_px", 32'(bus.pixel_x), 32'd1);

    // Random traffic including misplaced vflag
    repeat (3000) step(int'($urandom_range(0, 2047)), ($urandom_range(0, 99) < 3), 1'b0);

    // Walk to line 300, then reset together with vflag
    guard = 0;
    while (m_line != 300 && guard < 600) begin
      step(0, 1'b1, 1'b0);
      guard++;
    end
    chk("reach_line300", 32'(m_line), 32'd300);
    step(700, 1'b0, 1'b0);
    chk("line300_py", 32'(bus.pixel_y), 32'd300);
    step(700, 1'b1, 1'b1);
    chk_reset_vals("midreset");
    repeat (4) step(int'($urandom_range(1, 1599)), 1'b0, 1'b0);
    step(0, 1'b1, 1'b0);
    chk("post_reset_py", 32'(bus.pixel_y), 32'd1);
    chk("post_reset_von", 32'(bus.video_on), 32'd1);

    // Out-of-range horizontal count
    step(1700, 1'b0, 1'b0);
    chk("oor_von", 32'(bus.video_on), 32'd0);
    chk("oor_hsync", 32'(bus.hsync), 32'd1);
    chk("oor_px", 32'(bus.pixel_x), 32'd0);
    step(6, 1'b0, 1'b0);
    chk("oor_line_kept", 32'(bus.pixel_y), 32'd1);
    chk("oor_px_after", 32'(bus.pixel_x), 32'd3);

    step(10, 1'b0, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
